// File: rtl/hazard_pkg.sv
// +----------------------------------------------------------------------+
// | hazard_pkg                                                           |
// | Shared types and constants for the pipeline hazard controller.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package hazard_pkg;

  typedef enum logic [0:0] {
    HZ_RUN      = 1'b0,
    HZ_MEM_WAIT = 1'b1
  } hz_state_e;

  localparam logic [1:0] FWD_RS    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;
  localparam logic [1:0] RU_SRC_DM = 2'b01;

  // x0 is hardwired to zero, so a write to it never produces a usable value.
  function automatic logic reg_hit(input logic we, input logic [4:0] rd,
                                   input logic [4:0] src);
    return we && (rd != 5'd0) && (rd == src);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_unit_fwd_sel.sv
// +----------------------------------------------------------------------+
// | fwd_sel                                                              |
// | ALU operand forwarding select; the younger MEM result wins over WB.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] src_i,
  input  logic [4:0] mem_rd_i,
  input  logic       mem_ru_write_i,
  input  logic [4:0] wb_rd_i,
  input  logic       wb_ru_write_i,
  output logic [1:0] sel_o
);

  always_comb begin
    sel_o = FWD_RS;
    if (reg_hit(mem_ru_write_i, mem_rd_i, src_i)) begin
      sel_o = FWD_EXMEM;
    end else if (reg_hit(wb_ru_write_i, wb_rd_i, src_i)) begin
      sel_o = FWD_MEMWB;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_unit.sv
// +----------------------------------------------------------------------+
// | hazard_unit                                                          |
// | Stall/flush/forward control, memory-wait FSM and event counters.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       de_rs1,
  input  logic [4:0]       de_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_ru_write,
  input  logic [1:0]       ex_ru_data_src,
  input  logic [4:0]       mem_rd,
  input  logic             mem_ru_write,
  input  logic [4:0]       wb_rd,
  input  logic             wb_ru_write,
  input  logic             br_taken,
  input  logic             dm_busy,
  output logic             pc_enable,
  output logic             if_de_enable,
  output logic             de_ex_enable,
  output logic             ex_mem_enable,
  output logic             mem_wb_enable,
  output logic             if_de_flush,
  output logic             de_ex_flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [4:0] MAX_WAIT_C = 5'(MAX_WAIT);

  hz_state_e        state_q, state_d;
  logic [4:0]       wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic       load_use;
  logic       rule_freeze, rule_branch, rule_lu;
  logic [1:0] fwd_a, fwd_b;

  fwd_sel u_fwd_a (
    .src_i          (ex_rs1),
    .mem_rd_i       (mem_rd),
    .mem_ru_write_i (mem_ru_write),
    .wb_rd_i        (wb_rd),
    .wb_ru_write_i  (wb_ru_write),
    .sel_o          (fwd_a)
  );

  fwd_sel u_fwd_b (
    .src_i          (ex_rs2),
    .mem_rd_i       (mem_rd),
    .mem_ru_write_i (mem_ru_write),
    .wb_rd_i        (wb_rd),
    .wb_ru_write_i  (wb_ru_write),
    .sel_o          (fwd_b)
  );

  assign load_use = ex_ru_write && (ex_ru_data_src == RU_SRC_DM) &&
                    (ex_rd != 5'd0) && ((ex_rd == de_rs1) || (ex_rd == de_rs2));

  assign rule_freeze = dm_busy;
  assign rule_branch = !dm_busy && br_taken;
  assign rule_lu     = !dm_busy && !br_taken && load_use;

  always_comb begin
    pc_enable     = 1'b1;
    if_de_enable  = 1'b1;
    de_ex_enable  = 1'b1;
    ex_mem_enable = 1'b1;
    mem_wb_enable = 1'b1;
    if_de_flush   = 1'b0;
    de_ex_flush   = 1'b0;
    fwd_a_sel     = fwd_a;
    fwd_b_sel     = fwd_b;
    if (!rst_n) begin
      pc_enable     = 1'b0;
      if_de_enable  = 1'b0;
      de_ex_enable  = 1'b0;
      ex_mem_enable = 1'b0;
      mem_wb_enable = 1'b0;
      if_de_flush   = 1'b1;
      de_ex_flush   = 1'b1;
      fwd_a_sel     = FWD_RS;
      fwd_b_sel     = FWD_RS;
    end else if (rule_freeze) begin
      pc_enable     = 1'b0;
      if_de_enable  = 1'b0;
      de_ex_enable  = 1'b0;
      ex_mem_enable = 1'b0;
      mem_wb_enable = 1'b0;
    end else if (rule_branch) begin
      if_de_flush   = 1'b1;
      de_ex_flush   = 1'b1;
    end else if (rule_lu) begin
      pc_enable     = 1'b0;
      if_de_enable  = 1'b0;
      de_ex_flush   = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = 5'd0;
    case (state_q)
      HZ_RUN:      if (dm_busy)  state_d = HZ_MEM_WAIT;
      HZ_MEM_WAIT: if (!dm_busy) state_d = HZ_RUN;
      default:     state_d = HZ_RUN;
    endcase
    // wait_cnt holds the number of cycles already spent in MEM_WAIT.
    if (state_d == HZ_MEM_WAIT) begin
      wait_cnt_d = (wait_cnt_q == 5'h1f) ? wait_cnt_q : wait_cnt_q + 5'd1;
    end
    timeout_d = timeout_q ||
                ((state_q == HZ_MEM_WAIT) && (wait_cnt_q >= MAX_WAIT_C));
    stall_d = stall_q;
    if ((rule_freeze || rule_lu) && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
    flush_d = flush_q;
    if (rule_branch && (flush_q != '1)) flush_d = flush_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HZ_RUN;
      wait_cnt_q <= 5'd0;
      timeout_q  <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end

  assign mem_timeout = timeout_q;
  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule

`default_nettype wire

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the five-stage RISC-V core. It watches the decode, execute, memory and writeback stages and drives the enable, flush and forwarding controls back into the PC register and the `if_de`, `de_ex`, `ex_mem` and `mem_wb` pipeline registers. It also freezes the pipeline during multi-cycle data-memory accesses, flags memory timeouts, and keeps stall and flush performance counters.

## Interface
- `MAX_WAIT`, default 16: maximum consecutive `dm_busy` cycles before `mem_timeout` is set.
- `CNT_W`, default 32: width of the performance counters.
- `clk` input 1: core clock. All state changes on the rising edge.
- `rst_n` input 1: reset. Asynchronous and active-low.
- `de_rs1`, `de_rs2` input 5 each: source register addresses of the instruction in DE.
- `ex_rs1`, `ex_rs2` input 5 each: source addresses carried in the `de_ex` register.
- `ex_rd` input 5, `ex_ru_write` input 1, `ex_ru_data_src` input 2: destination register, write enable and writeback source of the instruction in EX. A value of 2'b01 in `ex_ru_data_src` marks a load.
- `mem_rd` input 5, `mem_ru_write` input 1: destination register and write enable of the instruction in MEM.
- `wb_rd` input 5, `wb_ru_write` input 1: destination register and write enable of the instruction in WB.
- `br_taken` input 1: the branch or jump in EX redirects the PC.
- `dm_busy` input 1: the data memory has not completed this cycle's access.
- `pc_enable`, `if_de_enable`, `de_ex_enable`, `ex_mem_enable`, `mem_wb_enable` output 1 each: register load enables.
- `if_de_flush`, `de_ex_flush` output 1 each: when high, the register loads a bubble (all control fields zero).
- `fwd_a_sel`, `fwd_b_sel` output 2 each: ALU operand source. 00 selects the `de_ex` RS value, 01 the EX/MEM ALU result, 10 the MEM/WB writeback data.
- `mem_timeout` output 1: sticky error flag.
- `stall_count`, `flush_count` output `CNT_W` each: saturating event counters.

## Operation
- **State machine.** Two states, RUN and MEM_WAIT, held in a state register.
  - RUN goes to MEM_WAIT when `dm_busy`=1.
  - MEM_WAIT goes to RUN when `dm_busy`=0.
  - A 5-bit saturating counter `wait_cnt` counts consecutive MEM_WAIT cycles. It is cleared when the state is RUN.
- **Control priority**, evaluated combinationally each cycle. Only the highest active rule applies.
  1. **Memory freeze** (`dm_busy`=1, in either state):
     - All five enables are 0 and both flushes are 0.
     - Everything holds, including any pending branch. A pending branch redirects on the first cycle after `dm_busy` falls.
  2. **Branch flush** (`br_taken`=1):
     - All enables are 1.
     - `if_de_flush`=1 and `de_ex_flush`=1.
     - A coincident load-use condition is ignored.
  3. **Load-use stall.**
     - Condition: `ex_ru_write` & (`ex_ru_data_src`==2'b01) & (`ex_rd`!=0) & ((`ex_rd`==`de_rs1`) | (`ex_rd`==`de_rs2`)).
     - Response: `pc_enable`=0, `if_de_enable`=0, `de_ex_flush`=1. All other enables are 1.
  4. **Normal:** all enables are 1 and both flushes are 0.
- **Forwarding for operand A.** The rule is the same for operand B, using `ex_rs2`.
  - If `mem_ru_write` & `mem_rd`!=0 & `mem_rd`==`ex_rs1`, then `fwd_a_sel` is 01.
  - Otherwise, if `wb_ru_write` & `wb_rd`!=0 & `wb_rd`==`ex_rs1`, then `fwd_a_sel` is 10.
  - Otherwise it is 00.
  - MEM takes priority over WB.
  - Forwarding selects are computed even during a freeze.
- **Timeout.** `mem_timeout` is set when `wait_cnt` reaches `MAX_WAIT` while in MEM_WAIT. It stays set until reset. It does not alter any stall behaviour.
- **Counters.**
  - `stall_count` increments on every cycle in which rule 1 or rule 3 is active.
  - `flush_count` increments on every cycle in which rule 2 is active.
  - Both counters saturate at all-ones.

## Timing
- Enable, flush and forwarding outputs are combinational from the current inputs. They take effect on the same rising edge as the hazard they resolve, with zero cycles of latency.
- State, `wait_cnt`, `mem_timeout` and both counters are registered.
- A load-use stall inserts exactly one bubble. On the next cycle the load is in MEM and is no longer matched by rule 3.
- A taken branch costs two bubbles: the IF/DE and DE/EX contents are discarded.
- **Reset** (`rst_n`=0, asynchronous):
  - State goes to RUN; `wait_cnt`, `mem_timeout`, `stall_count` and `flush_count` go to 0.
  - While reset is asserted, the combinational outputs are forced to: all enables 0, both flushes 1, both forwarding selects 00.
  - Reset asserted during MEM_WAIT abandons the wait immediately.
- Deassertion of `rst_n` is synchronised externally. The first edge after release evaluates the rules normally.

## Structure
- Shared package `hazard_pkg`:
  - Enum for the state machine: `HZ_RUN`, `HZ_MEM_WAIT`.
  - Forwarding-select constants: `FWD_RS`=2'b00, `FWD_EXMEM`=2'b01, `FWD_MEMWB`=2'b10.
  - Constant `RU_SRC_DM`=2'b01.
- One sub-module, `fwd_sel`, instantiated twice (operands A and B).
  - Inputs: source address, `mem_rd`, `mem_ru_write`, `wb_rd`, `wb_ru_write`.
  - Output: the 2-bit forwarding select.
- The FSM, counters and priority logic live in the top level.

## Test plan
- **Load-use:** EX holds a load to x5 and DE reads rs1=x5. Expect `pc_enable`=0, `if_de_enable`=0 and `de_ex_flush`=1 for one cycle, then normal operation; `stall_count` becomes 1.
- **x0 guard:** EX holds a load to x0 and DE reads rs1=x0. Expect no stall. With `mem_rd`=0 and `mem_ru_write`=1, expect `fwd_a_sel`=00.
- **Forwarding priority:** `ex_rs2`=x7, with both MEM and WB writing x7. Expect `fwd_b_sel`=01. With only WB writing x7, expect 10.
- **Branch vs load-use:** `br_taken`=1 and a load-use condition in the same cycle. Expect both flushes=1 and all enables=1; `flush_count` becomes 1 and `stall_count` is unchanged.
- **Memory wait:** hold `dm_busy`=1 for 3 cycles with `br_taken`=1. Expect all enables=0 and flushes=0 for 3 cycles, `stall_count`=3, then branch flush on cycle 4. With `dm_busy` held for 16 cycles, expect `mem_timeout`=1 and sticky.
- **Reset mid-wait:** pull `rst_n` low during MEM_WAIT, asynchronously between clock edges. Expect immediate forced outputs and counters=0. After release, expect state RUN.
